// File: rtl/alu_pkg.sv
// Definitions shared by the ALU and its issue controller: opcodes, instruction
// field layout, flag width and the issue FSM states.
package alu_pkg;

    localparam logic [7:0] OP_AND  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_LSH  = 8'h08;
    localparam logic [7:0] OP_MOV  = 8'h0D;
    localparam logic [7:0] OP_ASHU = 8'h0F;

    // Instruction word layout: [15:8] opcode, [7:4] Rdest, [3:0] Rsrc
    localparam int INSTR_W = 16;
    localparam int OPC_LSB = 8;
    localparam int OPC_W   = 8;
    localparam int RD_LSB  = 4;
    localparam int RS_LSB  = 0;
    localparam int RF_AW   = 4;
    localparam int DATA_W  = 16;
    localparam int FLAG_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_EXEC  = 2'd2
    } issue_state_e;

    function automatic logic isLegalOp(input logic [7:0] op);
        logic legal;
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_ADD,
            OP_LSH, OP_MOV, OP_ASHU: legal = 1'b1;
            default:                 legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/regfile16x16.sv
// General register file: one synchronous write port, three combinational read
// ports (source operand, destination operand, debug).
module regfile16x16
    import alu_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [RF_AW-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [RF_AW-1:0]  rsAddr_i,
    input  logic [RF_AW-1:0]  rdAddr_i,
    input  logic [RF_AW-1:0]  dbgAddr_i,
    output logic [DATA_W-1:0] rsData_o,
    output logic [DATA_W-1:0] rdData_o,
    output logic [DATA_W-1:0] dbgData_o
);

    logic [DATA_W-1:0] mem_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rsData_o  = mem_q[rsAddr_i];
    assign rdData_o  = mem_q[rdAddr_i];
    assign dbgData_o = mem_q[dbgAddr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one instruction at a time to the external ALU and writes the result
// back to the register file; three-state sequence IDLE -> ISSUE -> EXEC.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    input  logic               ld_en,
    input  logic [RF_AW-1:0]   ld_addr,
    input  logic [DATA_W-1:0]  ld_data,
    output logic [DATA_W-1:0]  alu_r1,
    output logic [DATA_W-1:0]  alu_r2,
    output logic [7:0]         alu_opcode,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic [FLAG_W-1:0]  alu_flags,
    output logic [FLAG_W-1:0]  psr_flags,
    output logic               done,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired,
    input  logic [RF_AW-1:0]   dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    issue_state_e       state_q;
    logic [INSTR_W-1:0] instr_q;
    logic [DATA_W-1:0]  aluR1_q;
    logic [DATA_W-1:0]  aluR2_q;
    logic [7:0]         aluOpcode_q;
    logic [FLAG_W-1:0]  psrFlags_q;
    logic               done_q;
    logic               illegal_q;
    logic [CNT_W-1:0]   retired_q;

    logic [7:0]         latchedOp;
    logic [RF_AW-1:0]   rdAddr;
    logic [RF_AW-1:0]   rsAddr;
    logic [DATA_W-1:0]  rsData;
    logic [DATA_W-1:0]  rdData;

    logic               rfWe_d;
    logic [RF_AW-1:0]   rfWaddr_d;
    logic [DATA_W-1:0]  rfWdata_d;

    assign latchedOp = instr_q[OPC_LSB +: OPC_W];
    assign rdAddr    = instr_q[RD_LSB +: RF_AW];
    assign rsAddr    = instr_q[RS_LSB +: RF_AW];

    // Host loads own the write port in IDLE, ALU writeback owns it in EXEC
    always_comb begin
        rfWe_d    = 1'b0;
        rfWaddr_d = '0;
        rfWdata_d = '0;
        if (state_q == ST_IDLE && ld_en) begin
            rfWe_d    = 1'b1;
            rfWaddr_d = ld_addr;
            rfWdata_d = ld_data;
        end else if (state_q == ST_EXEC) begin
            rfWe_d    = 1'b1;
            rfWaddr_d = rdAddr;
            rfWdata_d = alu_out;
        end
    end

    regfile16x16 #(
        .NREGS(NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (rfWe_d),
        .waddr_i  (rfWaddr_d),
        .wdata_i  (rfWdata_d),
        .rsAddr_i (rsAddr),
        .rdAddr_i (rdAddr),
        .dbgAddr_i(dbg_addr),
        .rsData_o (rsData),
        .rdData_o (rdData),
        .dbgData_o(dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            instr_q     <= '0;
            aluR1_q     <= '0;
            aluR2_q     <= '0;
            aluOpcode_q <= '0;
            psrFlags_q  <= '0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            retired_q   <= '0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Operands are read here, so a load at the accept edge is already visible
                    if (isLegalOp(latchedOp)) begin
                        aluR1_q     <= rsData;
                        aluR2_q     <= rdData;
                        aluOpcode_q <= latchedOp;
                        state_q     <= ST_EXEC;
                    end else begin
                        illegal_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    psrFlags_q <= alu_flags;
                    retired_q  <= retired_q + CNT_W'(1);
                    done_q     <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign alu_r1      = aluR1_q;
    assign alu_r2      = aluR2_q;
    assign alu_opcode  = aluOpcode_q;
    assign psr_flags   = psrFlags_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl; a small behavioural ALU closes the loop
// on the controller's operand/opcode outputs.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [15:0] ld_data;
    logic [15:0] alu_r1;
    logic [15:0] alu_r2;
    logic [7:0]  alu_opcode;
    logic [15:0] alu_out;
    logic [4:0]  alu_flags;
    logic [4:0]  psr_flags;
    logic        done;
    logic        illegal;
    logic [15:0] retired;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int checkCount;
    int errorCount;

    alu_issue_ctrl #(
        .NREGS(16),
        .CNT_W(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_ready(instr_ready),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .alu_r1     (alu_r1),
        .alu_r2     (alu_r2),
        .alu_opcode (alu_opcode),
        .alu_out    (alu_out),
        .alu_flags  (alu_flags),
        .psr_flags  (psr_flags),
        .done       (done),
        .illegal    (illegal),
        .retired    (retired),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: flags = {carry, zero, negative, parity, 0}
    logic [16:0] aluRes;
    always_comb begin
        aluRes = 17'h0;
        case (alu_opcode)
            8'h01: aluRes = {1'b0, alu_r1 & alu_r2};
            8'h02: aluRes = {1'b0, alu_r1 | alu_r2};
            8'h03: aluRes = {1'b0, alu_r1 ^ alu_r2};
            8'h05: aluRes = {1'b0, alu_r1} + {1'b0, alu_r2};
            8'h08: aluRes = {1'b0, alu_r2 << alu_r1};
            8'h0D: aluRes = {1'b0, alu_r1};
            8'h0F: aluRes = {1'b0, 16'($signed(alu_r2) >>> alu_r1)};
            default: aluRes = 17'h0;
        endcase
        alu_out   = aluRes[15:0];
        alu_flags = {aluRes[16], aluRes[15:0] == 16'h0, aluRes[15], ^aluRes[15:0], 1'b0};
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReg(input string tag, input logic [3:0] addr, input logic [15:0] exp);
        dbg_addr = addr;
        #1;
        checkOutput(tag, {16'h0, dbg_data}, {16'h0, exp});
    endtask

    task automatic loadReg(input logic [3:0] addr, input logic [15:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        step();
        ld_en   = 1'b0;
    endtask

    // Waits (bounded) for instr_ready, then presents the word for exactly one accept edge
    task automatic applyStimulus(input logic [15:0] word);
        int waitCyc;
        waitCyc = 0;
        while (!instr_ready && waitCyc < 10) begin
            step();
            waitCyc++;
        end
        if (!instr_ready) checkOutput("readyTimeout", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        instr       = word;
        step();
        instr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acceptCyc[$];
        int doneCnt;

        checkCount  = 0;
        errorCount  = 0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0;
        ld_en       = 1'b0;
        ld_addr     = 4'h0;
        ld_data     = 16'h0;
        dbg_addr    = 4'h0;

        // Reset with inputs wiggling
        step();
        instr_valid = 1'b1;
        instr       = 16'h0512;
        ld_en       = 1'b1;
        ld_addr     = 4'h3;
        ld_data     = 16'hFFFF;
        repeat (3) step();
        checkOutput("rstReady", 32'(instr_ready), 32'd1);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstRetired", 32'(retired), 32'd0);
        checkReg("rstWiggleR3", 4'h3, 16'h0000);
        instr_valid = 1'b0;
        ld_en       = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        checkOutput("relReady", 32'(instr_ready), 32'd1);
        checkOutput("relOpcode", 32'(alu_opcode), 32'd0);
        checkOutput("relPsr", 32'(psr_flags), 32'd0);
        checkOutput("relRetired", 32'(retired), 32'd0);
        for (int a = 0; a < 16; a++) checkReg("relRf", 4'(a), 16'h0000);

        // ADD r1 <= r1 + r2 with a load attempt outside IDLE
        loadReg(4'h1, 16'h0003);
        loadReg(4'h2, 16'h0005);
        applyStimulus(16'h0512);
        checkOutput("addIssueReady", 32'(instr_ready), 32'd0);
        ld_en   = 1'b1;
        ld_addr = 4'h7;
        ld_data = 16'hDEAD;
        step();
        ld_en   = 1'b0;
        checkOutput("addR1", 32'(alu_r1), 32'h0005);
        checkOutput("addR2", 32'(alu_r2), 32'h0003);
        checkOutput("addOp", 32'(alu_opcode), 32'h05);
        checkOutput("addDoneEarly", 32'(done), 32'd0);
        step();
        checkOutput("addDone", 32'(done), 32'd1);
        checkOutput("addReady", 32'(instr_ready), 32'd1);
        checkOutput("addRetired", 32'(retired), 32'd1);
        checkOutput("addPsr", 32'(psr_flags), 32'h02);
        checkReg("addResult", 4'h1, 16'h0008);
        step();
        checkOutput("addDoneLow", 32'(done), 32'd0);
        checkReg("ldIgnored", 4'h7, 16'h0000);

        // LSH then MOV with instr_valid held high
        loadReg(4'h3, 16'h0001);
        loadReg(4'h4, 16'h0004);
        loadReg(4'h6, 16'hBEEF);
        instr_valid = 1'b1;
        instr       = 16'h0834;
        doneCnt     = 0;
        for (int c = 0; c < 6; c++) begin
            if (instr_valid && instr_ready) acceptCyc.push_back(c);
            step();
            if (c == 0) instr = 16'h0D56;
            if (done) doneCnt++;
            if (c == 2) checkReg("lshResult", 4'h3, 16'h0010);
        end
        instr_valid = 1'b0;
        checkOutput("b2bAccepts", 32'(acceptCyc.size()), 32'd2);
        if (acceptCyc.size() == 2) begin
            checkOutput("b2bSpacing", 32'(acceptCyc[1] - acceptCyc[0]), 32'd3);
        end
        checkOutput("b2bDoneCnt", 32'(doneCnt), 32'd2);
        checkReg("movResult", 4'h5, 16'hBEEF);
        checkReg("movSrcKept", 4'h6, 16'hBEEF);
        checkReg("lshKept", 4'h3, 16'h0010);
        checkOutput("b2bRetired", 32'(retired), 32'd3);
        checkOutput("movPsr", 32'(psr_flags), 32'h06);

        // Illegal opcode 0x07
        applyStimulus(16'h0712);
        checkOutput("illEarly", 32'(illegal), 32'd0);
        step();
        checkOutput("illPulse", 32'(illegal), 32'd1);
        checkOutput("illNoDone", 32'(done), 32'd0);
        checkOutput("illReady", 32'(instr_ready), 32'd1);
        checkOutput("illOpKept", 32'(alu_opcode), 32'h0D);
        checkOutput("illR1Kept", 32'(alu_r1), 32'hBEEF);
        step();
        checkOutput("illLow", 32'(illegal), 32'd0);
        checkOutput("illNoDone2", 32'(done), 32'd0);
        checkReg("illR1", 4'h1, 16'h0008);
        checkReg("illR2", 4'h2, 16'h0005);
        checkOutput("illPsr", 32'(psr_flags), 32'h06);
        checkOutput("illRetired", 32'(retired), 32'd3);

        // Reset while in EXEC
        applyStimulus(16'h0512);
        step();
        checkOutput("rexInExec", 32'(alu_opcode), 32'h05);
        rst_n = 1'b0;
        #1;
        checkOutput("rexDone", 32'(done), 32'd0);
        checkOutput("rexReady", 32'(instr_ready), 32'd1);
        checkOutput("rexOpcode", 32'(alu_opcode), 32'd0);
        checkOutput("rexRetired", 32'(retired), 32'd0);
        step();
        checkOutput("rexNoDone", 32'(done), 32'd0);
        rst_n = 1'b1;
        step();
        checkOutput("rexNoDoneAfter", 32'(done), 32'd0);
        checkOutput("rexIdle", 32'(instr_ready), 32'd1);
        checkReg("rexR1", 4'h1, 16'h0000);

        // Load at the same edge as accepting MOV r1 <= r2
        ld_en       = 1'b1;
        ld_addr     = 4'h2;
        ld_data     = 16'h1234;
        instr_valid = 1'b1;
        instr       = 16'h0D12;
        step();
        ld_en       = 1'b0;
        instr_valid = 1'b0;
        step();
        checkOutput("colR1", 32'(alu_r1), 32'h1234);
        step();
        checkOutput("colDone", 32'(done), 32'd1);
        checkReg("colResult", 4'h1, 16'h1234);
        checkOutput("colRetired", 32'(retired), 32'd1);

        // Counter wrap
        force dut.retired_q = 16'hFFFF;
        step();
        checkOutput("wrapPreset", 32'(retired), 32'hFFFF);
        release dut.retired_q;
        applyStimulus(16'h0D12);
        step();
        step();
        checkOutput("wrapDone", 32'(done), 32'd1);
        checkOutput("wrapRetired", 32'(retired), 32'd0);

        // ASHU keeps the sign: 0x8000 >>> 4 = 0xF800
        loadReg(4'h8, 16'h8000);
        loadReg(4'h9, 16'h0004);
        applyStimulus(16'h0F89);
        step();
        step();
        checkOutput("ashuDone", 32'(done), 32'd1);
        checkReg("ashuResult", 4'h8, 16'hF800);
        checkOutput("ashuRetired", 32'(retired), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    always @(negedge clk) begin
        if (rst_n && done && illegal) begin
            errorCount++;
            $display("[TB] FAIL doneIllegalOverlap got=11 exp=not both");
        end
    end

endmodule
